// File: rtl/upum_pkt_pkg.sv
// Shared types and helpers for the UPUM packet parser: FSM states, error codes, CRC-8 step.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package upum_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CRC     = 2'b11;

    localparam logic [7:0] PKT_PREFIX_DEF = 8'hDD;

    // One byte of CRC-8, polynomial x^8+x^2+x+1 (0x07), MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Inter-byte gap timer: pulses o_expire when TIMEOUT_CYCLES cycles pass with no clear while enabled.
// Latency: o_expire is combinational from the count; counter reloads on the following edge.
// Backpressure: none; i_clear in the expiring cycle suppresses the pulse (the byte wins).
module pkt_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk_100,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Expiry happens on the TIMEOUT_CYCLES-th edge after the last clear.
    assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

    // Count idle cycles while enabled; any clear, disable or expiry restarts from zero.
    always_ff @(posedge clk_100) begin
        if (!n_rst || i_clear || !i_enable || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// Parses DD/addr/len/payload/crc frames from UART bytes; optional CRC-8 check under PKT_CRC_CHECK_EN.
// Latency: payload strobes and frame_done/frame_err appear one cycle after the carrying rx_valid.
// Backpressure: none; input is at most one byte every other cycle and outputs cannot stall.
module uart_pkt_parser
    import upum_pkt_pkg::*;
#(
    parameter logic [7:0] PREFIX         = PKT_PREFIX_DEF,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_100,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     r_state,     w_state_nxt;
    logic [7:0] r_addr,      w_addr_nxt;
    logic [7:0] r_len,       w_len_nxt;
    logic [7:0] r_remaining, w_remaining_nxt;
    logic [7:0] r_out_data,  w_out_data_nxt;
    logic       r_out_valid, w_out_valid_nxt;
    logic       r_out_first, w_out_first_nxt;
    logic       r_out_last,  w_out_last_nxt;
    logic       r_done,      w_done_nxt;
    logic       r_err,       w_err_nxt;
    logic [1:0] r_err_code,  w_err_code_nxt;
    logic       w_busy;
    logic       w_expire;
`ifdef PKT_CRC_CHECK_EN
    logic [7:0] r_crc,       w_crc_nxt;
`endif

    assign w_busy = (r_state != ST_IDLE);

    pkt_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_100  (clk_100),
        .n_rst    (n_rst),
        .i_clear  (rx_valid),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // Next-state and next-output decode; a timeout cannot coincide with rx_valid.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_len_nxt       = r_len;
        w_remaining_nxt = r_remaining;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        w_out_first_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_err_code_nxt  = r_err_code;
`ifdef PKT_CRC_CHECK_EN
        w_crc_nxt       = r_crc;
`endif
        if (w_expire) begin
            w_state_nxt    = ST_IDLE;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_TIMEOUT;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == PREFIX) begin
                        w_state_nxt = ST_ADDR;
`ifdef PKT_CRC_CHECK_EN
                        w_crc_nxt   = 8'h00;
`endif
                    end
                end
                ST_ADDR: begin
                    w_addr_nxt  = rx_data;
                    w_state_nxt = ST_LEN;
`ifdef PKT_CRC_CHECK_EN
                    w_crc_nxt   = crc8_step(r_crc, rx_data);
`endif
                end
                ST_LEN: begin
                    if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                        w_state_nxt    = ST_IDLE;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_LEN;
                    end else begin
                        w_len_nxt       = rx_data;
                        w_remaining_nxt = rx_data;
                        w_state_nxt     = ST_DATA;
                    end
`ifdef PKT_CRC_CHECK_EN
                    w_crc_nxt = crc8_step(r_crc, rx_data);
`endif
                end
                ST_DATA: begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = rx_data;
                    w_out_first_nxt = (r_remaining == r_len);
                    w_out_last_nxt  = (r_remaining == 8'd1);
                    w_remaining_nxt = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_state_nxt = ST_CRC;
                    end
`ifdef PKT_CRC_CHECK_EN
                    w_crc_nxt = crc8_step(r_crc, rx_data);
`endif
                end
                ST_CRC: begin
                    w_state_nxt = ST_IDLE;
`ifdef PKT_CRC_CHECK_EN
                    if (rx_data != r_crc) begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_CRC;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
`else
                    // Trailer byte is consumed without inspection.
                    w_done_nxt = 1'b1;
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any frame in flight without pulses.
    always_ff @(posedge clk_100) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 8'h00;
            r_len       <= 8'h00;
            r_remaining <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
`ifdef PKT_CRC_CHECK_EN
            r_crc       <= 8'h00;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_first <= w_out_first_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
`ifdef PKT_CRC_CHECK_EN
            r_crc       <= w_crc_nxt;
`endif
        end
    end

    assign out_addr   = r_addr;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_code   = r_err_code;
    assign busy       = w_busy;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed and random frames against a frame-level reference model; CRC expectations follow PKT_CRC_CHECK_EN.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_pkt_parser;

    localparam int T    = 300;
    localparam int MAXL = 64;

    logic       clk_100 = 1'b0;
    logic       n_rst   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk_100 = ~clk_100;

    uart_pkt_parser #(
        .PREFIX         (8'hDD),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_100    (clk_100),
        .n_rst      (n_rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       first;
        logic       last;
    } strobe_t;

    int         total = 0;
    int         bad   = 0;
    strobe_t    got_q[$];
    strobe_t    exp_q[$];
    logic [1:0] got_err_q[$];
    logic [1:0] exp_err_q[$];
    int         got_done = 0;
    int         exp_done = 0;
    int         both_hi  = 0;
    logic [7:0] tx_pl[$];

    // Passive monitor, sampled away from the active edge.
    always @(negedge clk_100) begin
        if (out_valid) got_q.push_back({out_addr, out_data, out_first, out_last});
        if (frame_done) got_done++;
        if (frame_err) got_err_q.push_back(err_code);
        if (frame_done && frame_err) both_hi++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-8 (0x07) as the remainder of message*x^8, walked bit by bit over addr, len, payload.
    function automatic logic [7:0] ref_crc(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] msg[$];
        logic [7:0] rem;
        logic       fb;
        msg.push_back(a);
        msg.push_back(l);
        foreach (tx_pl[i]) msg.push_back(tx_pl[i]);
        rem = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = rem[7] ^ msg[i][b];
                rem = {rem[6:0], 1'b0};
                if (fb) rem = rem ^ 8'h07;
            end
        end
        return rem;
    endfunction

    // Frame-level model: strobes for a legal length, then exactly one end indication.
    task automatic model_frame(input logic [7:0] a, input logic [7:0] l, input logic [7:0] c);
        if (l == 8'd0 || int'(l) > MAXL) begin
            exp_err_q.push_back(2'b10);
        end else begin
            for (int i = 0; i < int'(l); i++)
                exp_q.push_back({a, tx_pl[i], i == 0, i == int'(l) - 1});
`ifdef PKT_CRC_CHECK_EN
            if (ref_crc(a, l) == c) exp_done++;
            else exp_err_q.push_back(2'b11);
`else
            exp_done++;
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int extra);
        repeat (extra) @(posedge clk_100);
        @(posedge clk_100); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_100); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input logic [7:0] c, input int maxgap);
        send_byte(8'hDD, $urandom_range(0, maxgap));
        send_byte(a, $urandom_range(0, maxgap));
        send_byte(l, $urandom_range(0, maxgap));
        if (!(l == 8'd0 || int'(l) > MAXL)) begin
            foreach (tx_pl[i]) send_byte(tx_pl[i], $urandom_range(0, maxgap));
            send_byte(c, $urandom_range(0, maxgap));
        end
    endtask

    task automatic compare(input string tag);
        int n;
        repeat (4) @(posedge clk_100);
        #1;
        chk({tag, "_nstrobe"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_strobe"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk({tag, "_done"}, 32'(got_done), 32'(exp_done));
        chk({tag, "_nerr"}, 32'(got_err_q.size()), 32'(exp_err_q.size()));
        n = (got_err_q.size() < exp_err_q.size()) ? got_err_q.size() : exp_err_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_errcode"}, 32'(got_err_q[i]), 32'(exp_err_q[i]));
        end
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_both"}, 32'(both_hi), 32'd0);
        got_q.delete(); exp_q.delete();
        got_err_q.delete(); exp_err_q.delete();
        got_done = 0; exp_done = 0; both_hi = 0;
    endtask

    task automatic set_pl2(input logic [7:0] b0, input logic [7:0] b1);
        tx_pl.delete();
        tx_pl.push_back(b0);
        tx_pl.push_back(b1);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] a;
        logic [7:0] l;

        // Reset state.
        n_rst = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        chk("reset_outs", 32'({out_addr, out_data, out_valid, out_first, out_last,
                               frame_done, frame_err, err_code, busy}), 32'd0);
        n_rst = 1'b1;

        // Basic two-byte frame with a fixed trailer.
        set_pl2(8'h16, 8'h1D);
        model_frame(8'h08, 8'h02, 8'hCC);
        send_frame(8'h08, 8'h02, 8'hCC, 2);
        compare("basic");

        // Illegal lengths: zero and one past the maximum.
        tx_pl.delete();
        model_frame(8'h09, 8'h00, 8'h00);
        send_frame(8'h09, 8'h00, 8'h00, 1);
        compare("len0");
        model_frame(8'h09, 8'h41, 8'h00);
        send_frame(8'h09, 8'h41, 8'h00, 1);
        compare("len65");

        // Maximum length with a correct CRC.
        tx_pl.delete();
        for (int i = 1; i <= MAXL; i++) tx_pl.push_back(8'(i));
        c = ref_crc(8'h16, 8'h40);
        model_frame(8'h16, 8'h40, c);
        send_frame(8'h16, 8'h40, c, 1);
        compare("maxlen");

        // Timeout mid-payload, then a normal frame.
        send_byte(8'hDD, 0);
        send_byte(8'h08, 1);
        send_byte(8'h02, 0);
        send_byte(8'h16, 0);
        exp_q.push_back({8'h08, 8'h16, 1'b1, 1'b0});
        exp_err_q.push_back(2'b01);
        repeat (T + 5) @(posedge clk_100);
        compare("timeout");
        tx_pl.delete(); tx_pl.push_back(8'hAE);
        c = ref_crc(8'h08, 8'h01);
        model_frame(8'h08, 8'h01, c);
        send_frame(8'h08, 8'h01, c, 2);
        compare("after_to");

        // Garbage before a frame; payload byte equal to garbage is still data.
        send_byte(8'h55, 0);
        send_byte(8'hAA, 2);
        tx_pl.delete(); tx_pl.push_back(8'h55);
        model_frame(8'h15, 8'h01, 8'hCC);
        send_frame(8'h15, 8'h01, 8'hCC, 1);
        compare("garbage");

        // Prefix value inside the payload is plain data.
        set_pl2(8'hDD, 8'hDD);
        model_frame(8'h21, 8'h02, 8'h00);
        send_frame(8'h21, 8'h02, 8'h00, 1);
        compare("prefix_data");

        // Gap of exactly T cycles is accepted.
        tx_pl.delete(); tx_pl.push_back(8'h77);
        c = ref_crc(8'h30, 8'h01);
        model_frame(8'h30, 8'h01, c);
        send_byte(8'hDD, 0);
        send_byte(8'h30, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, T - 2);
        send_byte(c, 0);
        compare("gap_eq_T");

        // Gap of T+1 cycles times out; the late byte lands in idle and is ignored.
        send_byte(8'hDD, 0);
        send_byte(8'h31, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, T - 1);
        exp_err_q.push_back(2'b01);
        compare("gap_T1");

        // Correct CRC and CRC+1 on the same payload.
        set_pl2(8'h16, 8'h1D);
        c = ref_crc(8'h08, 8'h02);
        model_frame(8'h08, 8'h02, c);
        send_frame(8'h08, 8'h02, c, 1);
        compare("crc_ok");
        c = c + 8'd1;
        model_frame(8'h08, 8'h02, c);
        send_frame(8'h08, 8'h02, c, 1);
        compare("crc_bad");

        // Reset mid-payload: streamed bytes stay, no end pulse, everything cleared.
        send_byte(8'hDD, 0);
        send_byte(8'h08, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        exp_q.push_back({8'h08, 8'h11, 1'b1, 1'b0});
        exp_q.push_back({8'h08, 8'h22, 1'b0, 1'b0});
        @(posedge clk_100); #1;
        n_rst = 1'b0;
        @(posedge clk_100); #1;
        chk("midrst_outs", 32'({out_addr, out_data, out_valid, out_first, out_last,
                                frame_done, frame_err, err_code, busy}), 32'd0);
        n_rst = 1'b1;
        compare("midrst");
        set_pl2(8'h5A, 8'hA5);
        c = ref_crc(8'h42, 8'h02);
        model_frame(8'h42, 8'h02, c);
        send_frame(8'h42, 8'h02, c, 1);
        compare("after_rst");

        // Random frames.
        for (int f = 0; f < 12; f++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
            else
                l = 8'($urandom_range(1, MAXL));
            tx_pl.delete();
            if (!(l == 8'd0 || int'(l) > MAXL))
                for (int i = 0; i < int'(l); i++) tx_pl.push_back(8'($urandom));
            c = ($urandom_range(0, 1) == 0) ? ref_crc(a, l) : 8'($urandom);
            model_frame(a, l, c);
            send_frame(a, l, c, 3);
            compare("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
